edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
// PURPOSE
//  Collects rising edges from NUM_CH single-bit lines, holds each as a pending event and
//  issues one event at a time on a valid/ready port, in round-robin order.
//  Lets several edge-detected sources share one downstream consumer (interrupt/event sink).
//  Edges lost because their channel already holds a pending event are counted.
// PARAMETERS
//  NUM_CH  4  number of input channels (>=2)
//  CNT_W   8  width of saturating drop counter
//  CH_W    $clog2(NUM_CH)  derived localparam, channel index width
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  a_i          in   NUM_CH  level inputs, synchronous to clk
//  en_i         in   NUM_CH  per-channel enable mask
//  evt_valid_o  out  1       event available
//  evt_ready_i  in   1       consumer accepts event
//  evt_ch_o     out  CH_W    index of the offered channel
//  drop_clr_i   in   1       synchronous clear of drop counter
//  drop_cnt_o   out  CNT_W   saturating count of dropped edges
// BEHAVIOUR
//  - Reset (async, immediate): a_q=0, pending=0, state=IDLE, evt_valid_o=0, evt_ch_o=0,
//    drop_cnt_o=0, rr_ptr=NUM_CH-1 (channel 0 has first priority).
//  - rise[i] = a_i[i] & ~a_q[i] & en_i[i]; a_q <= a_i every cycle. a_i high on the first
//    cycle after reset counts as a rise.
//  - pending[i]: set on rise[i]; cleared when channel i loads into the output register;
//    cleared when en_i[i]=0 (flush). Load and rise on the same channel in the same cycle ->
//    pending stays set (new event, not a drop).
//  - Drop: rise[i] while pending[i]=1 and not cleared this cycle. drop_cnt_o += number of
//    dropped channels this cycle and saturates at 2^CNT_W-1. drop_clr_i=1 loads this cycle's
//    drop count instead (clear plus same-cycle drops).
//  - Latency: rise sampled at edge k -> pending at k -> evt_valid_o=1 at edge k+1 when IDLE.
//  - FSM IDLE: evt_valid_o=0. If any pending (and enabled), the rr_arbiter selects a
//    channel, loads evt_ch_o, clears its pending bit, sets rr_ptr=grant and moves to HOLD.
//  - FSM HOLD: evt_valid_o=1. evt_ch_o is stable until handshake (valid & ready).
//    * Handshake with any pending: load the next grant the same edge and stay in HOLD
//      (one event per cycle sustained).
//    * Handshake with none pending: go to IDLE.
//    * No handshake: hold. A new edge on the offered channel re-pends it; it is not a drop.
//  - RR: search starts at rr_ptr+1 and wraps modulo NUM_CH. Lowest index wins only
//    relative to that start.
//  - en_i deassert while a channel is offered in HOLD: offer is kept until accepted
//    (no retraction of valid).
//  - evt_ready_i is ignored in IDLE.
// STRUCTURE
//  - Package edge_evt_pkg: typedef enum logic {IDLE, HOLD} evt_state_t.
//  - Sub-module rr_arbiter #(N): inputs req[N], ptr[CH_W]; outputs gnt_valid, gnt_idx.
//    Purely combinational rotate/priority-encode.
//  - Top holds: a_q, pending, FSM, output registers, drop-count adder with saturation.
// TESTING
//  1 NUM_CH=4, ready=1. Pulse a_i[2] for 1 cycle -> single event ch=2 two edges after
//    the sample; valid low afterwards.
//  2 Rises on ch0,1,3 in the same cycle, ready=1 -> events ch0,ch1,ch3 on consecutive
//    cycles; then with rr_ptr=3, ch1+ch2 pending -> order ch1,ch2.
//  3 ready=0 with ch1 offered; two more edges on ch0 -> first pends, second drops;
//    drop_cnt_o=1; ch1 is held unchanged.
//  4 Force 300 drops with CNT_W=8 -> drop_cnt_o saturates at 255. drop_clr_i together
//    with one drop -> 1.
//  5 ch2 pending, en_i[2]=0 -> pending flushed, no event. A rise with en=0 is ignored.
//  6 Assert rst mid-HOLD -> evt_valid_o=0 the same instant. After release with a_i[0]=1
//    held -> one event ch0.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event arbiter.
// The FSM is either empty (IDLE) or offering one event (HOLD).
package edge_evt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } evt_state_t;

endpackage

// File: rtl/edge_event_arbiter_rr.sv
// Round-robin grant selection over a request vector.
// The search starts one past ptr and wraps, so ptr itself has the lowest priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    int unsigned w_idx;

    // Walk from farthest to nearest so the nearest requester is the last writer
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        for (int off = N; off >= 1; off--) begin
            w_idx = (int'(ptr) + off) % N;
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges per channel and offers them one at a time on a
// valid/ready port in round-robin order, counting edges lost to a full slot.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         a_i,
    input  logic [NUM_CH-1:0]         en_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
    input  logic                      drop_clr_i,
    output logic [CNT_W-1:0]          drop_cnt_o
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SUM_W = CNT_W + CH_W + 1;
    localparam logic [SUM_W-1:0] SAT = {{(CH_W+1){1'b0}}, {CNT_W{1'b1}}};

    evt_state_t        r_state;
    logic [NUM_CH-1:0] r_a_q;
    logic [NUM_CH-1:0] r_pending;
    logic              r_evt_valid;
    logic [CH_W-1:0]   r_evt_ch;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_req;
    logic              w_gnt_valid;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_load;
    logic [NUM_CH-1:0] w_load_mask;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_pending_nxt;
    logic [CH_W:0]     w_drop_num;
    logic [SUM_W-1:0]  w_base;
    logic [SUM_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_drop_nxt;

    assign w_rise = a_i & ~r_a_q & en_i;
    assign w_req  = r_pending & en_i;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_rr (
        .req      (w_req),
        .ptr      (r_rr_ptr),
        .gnt_valid(w_gnt_valid),
        .gnt_idx  (w_gnt_idx)
    );

    // In HOLD a load only happens on a handshake
    assign w_load = w_gnt_valid & ((r_state == IDLE) | evt_ready_i);
    assign w_load_mask = w_load ? (NUM_CH'(1) << w_gnt_idx) : '0;

    assign w_drop = w_rise & r_pending & ~w_load_mask;
    assign w_pending_nxt = (r_pending & ~w_load_mask & en_i) | w_rise;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_num = w_drop_num + {{CH_W{1'b0}}, w_drop[i]};
        end
    end

    assign w_base = drop_clr_i ? '0 : {{(CH_W+1){1'b0}}, r_drop_cnt};
    assign w_sum  = w_base + SUM_W'(w_drop_num);
    assign w_drop_nxt = (w_sum > SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_q       <= '0;
            r_pending   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_rr_ptr    <= CH_W'(NUM_CH - 1);
            r_drop_cnt  <= '0;
        end else begin
            r_a_q      <= a_i;
            r_pending  <= w_pending_nxt;
            r_drop_cnt <= w_drop_nxt;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_evt_ch    <= w_gnt_idx;
                        r_rr_ptr    <= w_gnt_idx;
                        r_evt_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (evt_ready_i) begin
                        if (w_gnt_valid) begin
                            r_evt_ch <= w_gnt_idx;
                            r_rr_ptr <= w_gnt_idx;
                        end else begin
                            r_evt_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign evt_valid_o = r_evt_valid;
    assign evt_ch_o    = r_evt_ch;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
